// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement sequencer and its reducer.
package meas_pkg;

    localparam int unsigned NUM_VALS   = 10;
    localparam int unsigned TRIM_SHIFT = 3;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [5:0] {
        StIdle     = 6'b00_0001,
        StIssue    = 6'b00_0010,
        StWaitBusy = 6'b00_0100,
        StWaitDone = 6'b00_1000,
        StReduce   = 6'b01_0000,
        StOutput   = 6'b10_0000
    } meas_state_e;

endpackage

// File: rtl/meas_reduce.sv
// Running sum/min/max accumulator fed one value per cycle by the sequencer.
module meas_reduce #(
    parameter int unsigned VAL_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [VAL_W-1:0] val_i,
    output logic [VAL_W+3:0] sum_o,
    output logic [VAL_W-1:0] min_o,
    output logic [VAL_W-1:0] max_o
);

    logic [VAL_W+3:0] sum_q, sum_d;
    logic [VAL_W-1:0] min_q, min_d;
    logic [VAL_W-1:0] max_q, max_d;

    always_comb begin
        sum_d = sum_q;
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            sum_d = {4'b0000, val_i};
            min_d = val_i;
            max_d = val_i;
        end else if (en_i) begin
            sum_d = sum_q + {4'b0000, val_i};
            min_d = (val_i < min_q) ? val_i : min_q;
            max_d = (val_i > max_q) ? val_i : max_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else begin
            sum_q <= sum_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    // Outputs include the current input so the last step can be registered directly.
    assign sum_o = sum_d;
    assign min_o = min_d;
    assign max_o = max_d;

endmodule

// File: rtl/meas_sequencer.sv
// Measurement sequencer: start/busy handshake, trimmed mean of 10 values, result handshake.
// Optional watchdog on the busy wait is enabled by defining MEAS_SEQ_TIMEOUT_EN.
module meas_sequencer
    import meas_pkg::*;
#(
    parameter int unsigned VAL_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             auto_en,
    output logic             m_start,
    input  logic             m_busy,
    input  logic [VAL_W-1:0] m_val [0:NUM_VALS-1],
    output logic             res_valid,
    input  logic             res_ready,
    output logic [VAL_W-1:0] res_data,
    output logic             res_err,
    output logic             idle
);

    meas_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] res_data_q, res_data_d;
    logic             res_err_q, res_err_d;

    logic             red_clear;
    logic             red_en;
    logic [VAL_W+3:0] red_sum;
    logic [VAL_W-1:0] red_min;
    logic [VAL_W-1:0] red_max;
    logic [VAL_W+3:0] trim_full;
    logic             timeout;

    meas_reduce #(
        .VAL_W (VAL_W)
    ) u_reduce (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (red_clear),
        .en_i    (red_en),
        .val_i   (m_val[idx_q]),
        .sum_o   (red_sum),
        .min_o   (red_min),
        .max_o   (red_max)
    );

    // Sum of ten values minus one min and one max leaves eight, so the shift is the mean.
    assign trim_full = red_sum - {4'b0000, red_min} - {4'b0000, red_max};

`ifdef MEAS_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           waiting;

    assign waiting = (state_q == StWaitBusy) || (state_q == StWaitDone);
    assign timeout = waiting && (wd_q == WdW'(TIMEOUT_CYC - 1));

    always_comb begin
        wd_d = '0;
        if (waiting && !timeout) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        red_clear  = 1'b0;
        red_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (timeout) begin
                    state_d    = StOutput;
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end else if (m_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (timeout) begin
                    state_d    = StOutput;
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end else if (!m_busy) begin
                    state_d = StReduce;
                    idx_d   = '0;
                end
            end
            StReduce: begin
                red_en    = 1'b1;
                red_clear = (idx_q == '0);
                if (idx_q == IDX_W'(NUM_VALS - 1)) begin
                    state_d    = StOutput;
                    idx_d      = '0;
                    res_data_d = trim_full[TRIM_SHIFT +: VAL_W];
                    res_err_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StOutput: begin
                if (res_ready) begin
                    state_d = auto_en ? StIssue : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    assign m_start   = (state_q == StIssue);
    assign res_valid = (state_q == StOutput);
    assign idle      = (state_q == StIdle);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// Self-checking bench for meas_sequencer: vector table plus multi-cycle corner sequences.
module tb_meas_sequencer;

    localparam int unsigned VAL_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic             auto_en;
    logic             m_start;
    logic             m_busy;
    logic [VAL_W-1:0] m_val [0:9];
    logic             res_valid;
    logic             res_ready;
    logic [VAL_W-1:0] res_data;
    logic             res_err;
    logic             idle;

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [9:0][31:0] v;
        logic [7:0]       busy;
        logic [31:0]      exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl [0:6];

    meas_sequencer #(
        .VAL_W       (VAL_W),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .auto_en   (auto_en),
        .m_start   (m_start),
        .m_busy    (m_busy),
        .m_val     (m_val),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_start) n_starts <= n_starts + 1;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input vec_t t);
        for (int i = 0; i < 10; i++) m_val[i] = t.v[i];
    endtask

    // Pulse req from IDLE; leaves the bench one cycle into WAIT_BUSY.
    task automatic start_meas(input string tag, input bit push, input logic [31:0] d,
                              input logic e);
        req = 1'b1;
        tick();
        req = 1'b0;
        check({tag, " m_start_hi"}, m_start, 1);
        if (push) sb_q.push_back('{data: d, err: e});
        tick();
        check({tag, " m_start_lo"}, m_start, 0);
    endtask

    task automatic busy_pulse(input int n);
        m_busy = 1'b1;
        repeat (n) tick();
        m_busy = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int limit, output int cycles);
        cycles = 0;
        while (!res_valid && cycles < limit) begin
            tick();
            cycles++;
        end
        check({tag, " res_valid"}, res_valid, 1);
    endtask

    task automatic take_result(input string tag);
        exp_t        e;
        logic [31:0] d;
        logic        er;
        d = res_data;
        er = res_err;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, " sb_pending"}, (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, " res_data"}, d, e.data);
            check({tag, " res_err"}, er, e.err);
        end
    endtask

    task automatic full_meas(input string tag, input vec_t t);
        int cyc;
        int s0;
        load_vec(t);
        s0 = n_starts;
        start_meas(tag, 1'b1, t.exp, 1'b0);
        busy_pulse(int'(t.busy));
        wait_valid(tag, 40, cyc);
        check({tag, " one_start"}, n_starts - s0, 1);
        if (res_valid) take_result(tag);
        check({tag, " idle_after"}, idle, 1);
    endtask

    initial begin
        int          cyc;
        int          s0;
        bit          seen;
        int          a4 [10];
        rst_n     = 1'b0;
        req       = 1'b0;
        auto_en   = 1'b0;
        m_busy    = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < 10; i++) m_val[i] = '0;

        a4 = '{5, 5, 5, 9, 9, 1, 1, 9, 3, 4};
        for (int i = 0; i < 10; i++) begin
            tbl[0].v[i] = 32'(100 + i);
            tbl[1].v[i] = 32'd7;
            tbl[2].v[i] = 32'd0;
            tbl[3].v[i] = 32'hFFFF_FFFF;
            tbl[4].v[i] = 32'(a4[i]);
            tbl[5].v[i] = 32'(i);
            tbl[6].v[i] = 32'(100 - 10 * i);
        end
        tbl[1].v[3] = 32'd0;
        tbl[1].v[8] = 32'd1000;
        tbl[5].v[9] = 32'd80;
        tbl[0].busy = 8'd5; tbl[0].exp = 32'd104;
        tbl[1].busy = 8'd1; tbl[1].exp = 32'd7;
        tbl[2].busy = 8'd2; tbl[2].exp = 32'd0;
        tbl[3].busy = 8'd3; tbl[3].exp = 32'hFFFF_FFFF;
        tbl[4].busy = 8'd2; tbl[4].exp = 32'd5;
        tbl[5].busy = 8'd4; tbl[5].exp = 32'd4;
        tbl[6].busy = 8'd1; tbl[6].exp = 32'd55;

        repeat (3) tick();
        check("rst m_start", m_start, 0);
        check("rst res_valid", res_valid, 0);
        check("rst res_data", res_data, 0);
        check("rst res_err", res_err, 0);
        check("rst idle", idle, 1);
        rst_n = 1'b1;
        tick();
        check("post_rst idle", idle, 1);

        for (int k = 0; k < 7; k++) full_meas($sformatf("vec%0d", k), tbl[k]);

        // Result held while the consumer stalls, then auto re-issue on the handshake.
        load_vec(tbl[0]);
        start_meas("hold", 1'b1, tbl[0].exp, 1'b0);
        busy_pulse(2);
        wait_valid("hold", 40, cyc);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("hold%0d res_valid", i), res_valid, 1);
            check($sformatf("hold%0d res_data", i), res_data, tbl[0].exp);
        end
        auto_en = 1'b1;
        take_result("hold");
        auto_en = 1'b0;
        check("auto m_start", m_start, 1);
        sb_q.push_back('{data: tbl[0].exp, err: 1'b0});
        tick();
        busy_pulse(1);
        wait_valid("auto", 40, cyc);
        if (res_valid) take_result("auto");
        check("auto idle_after", idle, 1);

        // req during WAIT_DONE must not spawn a second measurement.
        load_vec(tbl[1]);
        s0 = n_starts;
        start_meas("ign", 1'b1, tbl[1].exp, 1'b0);
        m_busy = 1'b1;
        tick();
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        m_busy = 1'b0;
        wait_valid("ign", 40, cyc);
        if (res_valid) take_result("ign");
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (res_valid || !idle) seen = 1'b1;
        end
        check("ign no_second_result", seen, 0);
        check("ign one_start", n_starts - s0, 1);
        check("ign sb_empty", sb_q.size(), 0);

        // Reset in the middle of REDUCE.
        load_vec(tbl[5]);
        start_meas("rstmid", 1'b0, '0, 1'b0);
        busy_pulse(2);
        repeat (4) tick();
        check("rstmid busy_not_idle", idle, 0);
        rst_n = 1'b0;
        #2;
        check("rstmid m_start", m_start, 0);
        check("rstmid res_valid", res_valid, 0);
        check("rstmid res_data", res_data, 0);
        check("rstmid res_err", res_err, 0);
        check("rstmid idle", idle, 1);
        tick();
        rst_n = 1'b1;
        tick();
        full_meas("after_rst", tbl[6]);

        // Watchdog: m_busy never rises.
        load_vec(tbl[0]);
`ifdef MEAS_SEQ_TIMEOUT_EN
        start_meas("wdog", 1'b1, '0, 1'b1);
        wait_valid("wdog", 100, cyc);
        check("wdog wait_cycles", cyc, 50);
        if (res_valid) take_result("wdog");
        check("wdog idle_after", idle, 1);
`else
        start_meas("wdog", 1'b0, '0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (res_valid || idle || m_start) seen = 1'b1;
        end
        check("wdog stuck_waiting", seen, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("wdog idle_after_rst", idle, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/meas_sequencer.md
MEAS_SEQUENCER -- requirements
Module: meas_sequencer

Interface
REQ-001 SHALL have parameter VAL_W, default 32, width of each counter value and of the result.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000, watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  level request for one measurement, sampled only in IDLE.
REQ-006 SHALL have port auto_en  input  1  continuous re-measure after each result handshake.
REQ-007 SHALL have port m_start  output  1  start strobe to the measurement unit.
REQ-008 SHALL have port m_busy  input  1  measurement unit busy flag.
REQ-009 SHALL have port m_val  input  10 x VAL_W  unpacked array [0:9] of counter values, treated as unsigned.
REQ-010 SHALL have port res_valid  output  1  result available.
REQ-011 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port res_data  output  VAL_W  trimmed mean of the 10 values.
REQ-013 SHALL have port res_err  output  1  result invalid, caused by a timeout.
REQ-014 SHALL have port idle  output  1  high only in state IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, REDUCE, OUTPUT (one-hot encoding).
REQ-016 SHALL go IDLE->ISSUE on the clock edge where req=1; req in any other state is ignored and not queued.
REQ-017 SHALL drive m_start=1 for exactly the one cycle spent in ISSUE, then go to WAIT_BUSY.
REQ-018 SHALL go WAIT_BUSY->WAIT_DONE on the first cycle m_busy=1.
REQ-019 SHALL go WAIT_DONE->REDUCE on the first cycle m_busy=0.
REQ-020 SHALL spend exactly 10 cycles in REDUCE, one per index 0..9, accumulating sum (VAL_W+4 bits), min and max from registered m_val[index].
REQ-021 SHALL initialise the sum, min and max accumulators on REDUCE entry from m_val[0]: sum=m_val[0], min=max=m_val[0].
REQ-022 SHALL, on leaving REDUCE, register res_data=(sum-min-max)>>3 (truncating), res_err=0, and enter OUTPUT.
REQ-023 SHALL hold res_valid=1 with res_data and res_err stable in OUTPUT until res_ready=1.
REQ-024 SHALL, on the handshake cycle, go to ISSUE if auto_en=1, else to IDLE.
REQ-025 SHALL produce the same result when min or max appears more than once; exactly one instance of each is removed.
REQ-026 SHALL have a latency from req sampled to res_valid of 3 + (busy wait cycles) + 10 + 1 cycles.

Reset
REQ-027 SHALL, when rst_n=0 at any time (including mid-measurement), force state=IDLE, m_start=0, res_valid=0, res_data=0, res_err=0, idle=1, and clear all accumulators and counters.
REQ-028 SHALL leave state IDLE only on a clock edge where rst_n=1.

Configuration
REQ-029 SHALL implement the watchdog only when macro MEAS_SEQ_TIMEOUT_EN is defined.
REQ-030 SHALL, when MEAS_SEQ_TIMEOUT_EN is defined, count the cycles spent in WAIT_BUSY plus WAIT_DONE; on reaching TIMEOUT_CYC, enter OUTPUT with res_err=1 and res_data=0.
REQ-031 SHALL, without MEAS_SEQ_TIMEOUT_EN, wait indefinitely in WAIT_BUSY and WAIT_DONE; res_err is then tied to 0.

Structure
REQ-032 SHALL take the state enum type, the value count 10 and the trim shift 3 from a shared package meas_pkg.
REQ-033 SHALL place the sum/min/max accumulation in one sub-module, meas_reduce, with controls clear, enable and input value, and outputs sum, min and max.

Verification
REQ-034 SHALL verify: req pulse, m_busy high 5 cycles, m_val = 100,101,...,109 -> one m_start pulse, then res_valid with res_data=104 and res_err=0.
REQ-035 SHALL verify: m_val all 7 except [3]=0 and [8]=1000 -> res_data=7.
REQ-036 SHALL verify: res_ready held low 20 cycles -> res_valid and res_data stable for all 20 cycles; with auto_en=1, ISSUE is entered on the cycle after the handshake.
REQ-037 SHALL verify: with MEAS_SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=50 and m_busy never asserted -> res_err=1 and res_data=0 after 50 wait cycles; without the macro, the block stays in WAIT_BUSY.
REQ-038 SHALL verify: rst_n pulsed low during REDUCE -> all outputs return to reset values; a following req yields a correct result.
REQ-039 SHALL verify: req asserted during WAIT_DONE -> ignored, exactly one result is produced.
